// File: rtl/fmap_pingpong_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : fmap_pingpong_buffer_if
// Brief    : Pixel-stream bundle for the feature-map ping-pong buffer.
//            The write side carries the pooled pixel stream in. The read
//            side carries the replayed frame out to the next layer.
// Revision : 1.0 - initial release
// ============================================================================
interface fmap_pingpong_buffer_if #(
  parameter int DATA_W = 16
);
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              valid_out;
  logic [DATA_W-1:0] data_out;
  logic              frame_start;
  logic              frame_done;
  logic              overflow;

  // Producer / consumer side: drives pixels in and observes the replay.
  modport master (
    output wr_valid, wr_data,
    input  valid_out, data_out, frame_start, frame_done, overflow
  );

  // Buffer side.
  modport slave (
    input  wr_valid, wr_data,
    output valid_out, data_out, frame_start, frame_done, overflow
  );
endinterface
`default_nettype wire

// File: rtl/fmap_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fmap_pingpong_buffer
// Brief    : Double-buffered feature-map hand-off between two conv layers.
//            The pooled pixel stream is captured into one of two banks.
//            A completed bank is replayed in raster order while the other
//            bank fills. The optional macro FMAP_BUF_ROW_GAP_EN inserts
//            ROW_GAP idle cycles between output rows.
// Revision : 1.0 - initial release
// ============================================================================
module fmap_pingpong_buffer #(
  parameter int WIDTH   = 4,
  parameter int DATA_W  = 16,
  parameter int ROW_GAP = 2
) (
  input wire clk,
  input wire rst,      // asynchronous, active low
  fmap_pingpong_buffer_if.slave bus
);

  localparam int c_DEPTH = WIDTH * WIDTH;
  localparam int c_AW    = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;
  localparam int c_CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int c_GW    = (ROW_GAP > 0) ? $clog2(ROW_GAP + 1) : 1;
  localparam logic [c_AW-1:0] c_LAST_ADDR = c_AW'(c_DEPTH - 1);
  localparam logic [c_CW-1:0] c_LAST_COL  = c_CW'(WIDTH - 1);
`ifdef FMAP_BUF_ROW_GAP_EN
  localparam logic [c_GW-1:0] c_GAP_LOAD  = c_GW'(ROW_GAP);
`else
  localparam logic [c_GW-1:0] c_GAP_LOAD  = '0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  // Two banks laid out back to back; the bank pointer is the address MSB.
  logic [DATA_W-1:0] r_mem [2**(c_AW+1)];

  // Write side
  logic [c_AW-1:0] r_wa;
  logic            r_wb;
  logic            r_overflow;
  logic [1:0]      r_full;
  logic            w_wr_accept;
  logic            w_wr_drop;
  logic            w_wr_last;
  logic [1:0]      w_set_mask;
  logic [1:0]      w_clr_mask;

  // Read side
  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_rb;
  logic [c_AW-1:0] r_ra;
  logic [c_AW-1:0] w_ra_nxt;
  logic [c_CW-1:0] r_col;
  logic [c_CW-1:0] w_col_nxt;
  logic [c_GW-1:0] r_gap;
  logic [c_GW-1:0] w_gap_nxt;
  logic            w_issue;
  logic            w_clr;

  // Output registers
  logic              r_valid_out;
  logic [DATA_W-1:0] r_data_out;
  logic              r_frame_start;
  logic              r_frame_done;

  // A word is dropped only when the bank it would land in still awaits replay.
  assign w_wr_accept = bus.wr_valid & ~r_full[r_wb];
  assign w_wr_drop   = bus.wr_valid &  r_full[r_wb];
  assign w_wr_last   = w_wr_accept & (r_wa == c_LAST_ADDR);
  assign w_set_mask  = {w_wr_last & r_wb, w_wr_last & ~r_wb};
  assign w_clr_mask  = {w_clr & r_rb, w_clr & ~r_rb};

  // Bank storage: no reset, so contents survive a reset.
  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_mem[{r_wb, r_wa}] <= bus.wr_data;
    end
  end

  // Write address / bank pointer and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wa       <= '0;
      r_wb       <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_wr_accept) begin
        if (w_wr_last) begin
          r_wa <= '0;
          r_wb <= ~r_wb;
        end else begin
          r_wa <= r_wa + 1'b1;
        end
      end
    end
  end

  // Bank-full flags: set by the writer, cleared by the reader; clear wins on a tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full <= 2'b00;
    end else begin
      r_full <= (r_full | w_set_mask) & ~w_clr_mask;
    end
  end

  // Read FSM state, read address, column and row-gap counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_rb    <= 1'b0;
      r_ra    <= '0;
      r_col   <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ra    <= w_ra_nxt;
      r_col   <= w_col_nxt;
      r_gap   <= w_gap_nxt;
      if (w_clr) begin
        r_rb <= ~r_rb;
      end
    end
  end

  // Read FSM next state. r_ra is the flat raster address (row*WIDTH+col),
  // so a column wrap with a row increment is just a +1 on r_ra.
  always_comb begin
    w_state_nxt = r_state;
    w_ra_nxt    = r_ra;
    w_col_nxt   = r_col;
    w_gap_nxt   = r_gap;
    w_issue     = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_full[r_rb]) begin
          w_state_nxt = S_STREAM;
          w_ra_nxt    = '0;
          w_col_nxt   = '0;
          w_gap_nxt   = '0;
        end
      end
      S_STREAM: begin
        if (r_gap != '0) begin
          w_gap_nxt = r_gap - 1'b1;
        end else begin
          w_issue = 1'b1;
          if (r_ra == c_LAST_ADDR) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_ra_nxt = r_ra + 1'b1;
            if (r_col == c_LAST_COL) begin
              w_col_nxt = '0;
              w_gap_nxt = c_GAP_LOAD;
            end else begin
              w_col_nxt = r_col + 1'b1;
            end
          end
        end
      end
      S_DRAIN: begin
        w_clr       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered read stage: one-cycle memory latency feeding the outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid_out   <= 1'b0;
      r_data_out    <= '0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_valid_out   <= w_issue;
      r_frame_start <= w_issue & (r_ra == '0);
      r_frame_done  <= w_issue & (r_ra == c_LAST_ADDR);
      if (w_issue) begin
        r_data_out <= r_mem[{r_rb, r_ra}];
      end
    end
  end

  assign bus.valid_out   = r_valid_out;
  assign bus.data_out    = r_data_out;
  assign bus.frame_start = r_frame_start;
  assign bus.frame_done  = r_frame_done;
  assign bus.overflow    = r_overflow;

`ifndef SYNTHESIS
  // The writer only sets an empty flag and the reader only clears a full one,
  // so both can never target the same bank in one cycle.
  a_set_clr_same_bank: assert property (@(posedge clk) disable iff (!rst)
    (w_set_mask & w_clr_mask) == 2'b00);
`endif

endmodule
`default_nettype wire

// File: tb/tb_fmap_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fmap_pingpong_buffer
// Brief    : Self-checking bench for fmap_pingpong_buffer with a frame-level
//            reference model (bank arrays, full flags, replay timer).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fmap_pingpong_buffer;

  localparam int W         = 4;
  localparam int DW        = 16;
  localparam int ROW_GAP_P = 2;
  localparam int N         = W * W;
`ifdef FMAP_BUF_ROW_GAP_EN
  localparam int GAP = ROW_GAP_P;
`else
  localparam int GAP = 0;
`endif
  localparam int L = N + (W - 1) * GAP;   // read cycles per frame, drain excluded

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fmap_pingpong_buffer_if #(.DATA_W(DW)) bus ();

  fmap_pingpong_buffer #(
    .WIDTH  (W),
    .DATA_W (DW),
    .ROW_GAP(ROW_GAP_P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference model state
  logic [DW-1:0] m_mem [2][N];
  bit            m_full [2];
  int            m_wb, m_wa, m_rb, m_rt;   // m_rt: -1 idle, else cycles into replay
  bit            m_ovf;
  bit            e_valid, e_start, e_done;
  logic [DW-1:0] e_data;
  int            e_idx;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full  = '{0, 0};
    m_wb    = 0;
    m_wa    = 0;
    m_rb    = 0;
    m_rt    = -1;
    m_ovf   = 1'b0;
    e_valid = 1'b0;
    e_start = 1'b0;
    e_done  = 1'b0;
    e_idx   = -1;
  endtask

  // One clock edge of the model; all decisions use the pre-edge state.
  task automatic model_edge(input bit v, input logic [DW-1:0] d);
    int rt_n, rb_n, clr, set, row, col;
    rt_n = m_rt; rb_n = m_rb; clr = -1; set = -1;
    e_valid = 1'b0; e_start = 1'b0; e_done = 1'b0; e_idx = -1;
    if (m_rt < 0) begin
      if (m_full[m_rb]) rt_n = 0;
    end else if (m_rt < L) begin
      row = m_rt / (W + GAP);
      col = m_rt % (W + GAP);
      if (col < W) begin
        e_idx   = row * W + col;
        e_valid = 1'b1;
        e_data  = m_mem[m_rb][e_idx];
        e_start = (e_idx == 0);
        e_done  = (e_idx == N - 1);
      end
      rt_n = m_rt + 1;
    end else begin
      clr  = m_rb;
      rb_n = 1 - m_rb;
      rt_n = -1;
    end
    if (v) begin
      if (m_full[m_wb]) begin
        m_ovf = 1'b1;
      end else begin
        m_mem[m_wb][m_wa] = d;
        if (m_wa == N - 1) begin
          set  = m_wb;
          m_wa = 0;
          m_wb = 1 - m_wb;
        end else begin
          m_wa++;
        end
      end
    end
    if (set >= 0) m_full[set] = 1'b1;
    if (clr >= 0) m_full[clr] = 1'b0;
    m_rt = rt_n;
    m_rb = rb_n;
  endtask

  task automatic compare_outputs();
    check_value("valid_out",   bus.valid_out,   e_valid);
    check_value("frame_start", bus.frame_start, e_start);
    check_value("frame_done",  bus.frame_done,  e_done);
    check_value("overflow",    bus.overflow,    m_ovf);
    if (e_valid) check_value("data_out", bus.data_out, e_data);
  endtask

  // Called at a falling edge: drive, clock, model, then check at the next falling edge.
  task automatic step(input bit v, input logic [DW-1:0] d);
    bus.wr_valid = v;
    bus.wr_data  = d;
    @(posedge clk);
    model_edge(v, d);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, DW'($urandom));
  endtask

  task automatic write_frame(input int base);
    for (int i = 0; i < N; i++) step(1'b1, DW'(base + i));
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    compare_outputs();
    rst = 1'b1;
  endtask

  initial begin
    rst          = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_outputs();
    check_value("reset_data_out", bus.data_out, 0);
    rst = 1'b1;

    // Single frame 0..15, back to back
    write_frame(0);
    idle(L + 6);

    // Ping-pong: A then B with no gap between frames
    write_frame(0);
    write_frame(100);
    idle(2 * L + 10);

    // Gapped input, every other cycle
    for (int i = 0; i < N; i++) begin
      step(1'b1, DW'(200 + i));
      step(1'b0, DW'($urandom));
    end
    idle(L + 6);

    // Three back-to-back frames while reading: the third overruns
    for (int f = 0; f < 3; f++) write_frame(1000 * (f + 1));
    idle(3 * L + 10);
    check_value("overflow_sticky", bus.overflow, 1);

    // Reset in the middle of the replay, at output word 7
    reset_pulse();
    check_value("overflow_cleared", bus.overflow, 0);
    write_frame(300);
    for (int k = 0; k < L + 8; k++) begin
      if (e_valid && e_idx == 7) break;
      step(1'b0, '0);
    end
    #2 rst = 1'b0;
    #1;
    check_value("async_valid_out",   bus.valid_out,   0);
    check_value("async_frame_start", bus.frame_start, 0);
    check_value("async_frame_done",  bus.frame_done,  0);
    model_reset();
    repeat (3) begin
      @(negedge clk);
      compare_outputs();
    end
    rst = 1'b1;
    idle(10);
    for (int i = 0; i < N - 1; i++) step(1'b1, DW'(400 + i));
    idle(10);
    step(1'b1, DW'(400 + N - 1));
    idle(L + 6);

    // Random traffic, including overruns
    reset_pulse();
    for (int i = 0; i < 400; i++) step($urandom_range(0, 3) != 0, DW'($urandom));
    idle(3 * L + 10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
